btn_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the game FSM's `btn` input. It synchronises the three raw push-buttons, debounces each one independently, and converts each accepted press into a single-cycle one-hot pulse. The game logic therefore sees exactly one pulse per physical press. Press-and-hold lockout prevents repeated or overlapping presses from generating extra pulses, and chorded presses are flagged instead of passed on.

---
 rtl/btn_conditioner.sv | 110 +++++++++++
 tb/tb_btn_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises three raw push-buttons, debounces each bit
// independently and turns every accepted press into a single one-hot pulse.
// Presses arriving while another button is held are locked out; chorded
// presses raise multi_press instead of a pulse.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] btn_raw,
   input  logic       enable,
   output logic [2:0] btn_level,
   output logic [2:0] btn_pulse,
   output logic       multi_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {S_IDLE, S_HELD} state_t;

   logic [2:0]         w_raw;
   logic [2:0]         r_sync1, r_sync2;
   logic [2:0][CW-1:0] r_cnt;
   logic [2:0]         r_level, r_level_d;
   logic [2:0]         r_pulse;
   logic               r_multi;
   logic [2:0]         w_rise;
   logic [2:0]         w_pulse_nxt;
   logic               w_multi_nxt;
   state_t             r_state, w_state_nxt;

   // Polarity is normalised before the first flop so everything downstream is active-high.
   assign w_raw  = ACTIVE_LOW ? ~btn_raw : btn_raw;
   assign w_rise = r_level & ~r_level_d;

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Per-bit debounce: a changed input must persist DEBOUNCE_CYCLES edges; any bounce restarts the count.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt     <= '0;
         r_level   <= '0;
         r_level_d <= '0;
      end else begin
         r_level_d <= r_level;
         for (int b = 0; b < 3; b++) begin
            if (r_sync2[b] != r_level[b]) begin
               if (r_cnt[b] == CNT_MAX) begin
                  r_level[b] <= r_sync2[b];
                  r_cnt[b]   <= '0;
               end else begin
                  r_cnt[b] <= r_cnt[b] + 1'b1;
               end
            end else begin
               r_cnt[b] <= '0;
            end
         end
      end
   end

   // Press FSM state and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pulse <= '0;
         r_multi <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pulse <= w_pulse_nxt;
         r_multi <= w_multi_nxt;
      end
   end

   // Press FSM next state: accept one rise from IDLE, then lock out until every button is released.
   always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = '0;
      w_multi_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise != '0) begin
               // The press is consumed even when enable is low; it is never replayed.
               w_state_nxt = S_HELD;
               if ($onehot(w_rise)) w_pulse_nxt = enable ? w_rise : 3'b000;
               else                 w_multi_nxt = enable;
            end
         end
         S_HELD: begin
            if (r_level == '0) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign btn_level   = r_level;
   assign btn_pulse   = r_pulse;
   assign multi_press = r_multi;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (D = 4). An active-high and an
// active-low instance see the same buttons and must both follow one
// behavioural model built from a sliding window of synchronised samples.
module tb_btn_conditioner;

   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] btn_raw = 3'b000;
   logic       enable = 1'b1;
   logic [2:0] lvl_h, pls_h, lvl_l, pls_l;
   logic       mp_h, mp_l;

   int checks = 0;
   int errors = 0;

   btn_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) u_dut_h (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .enable(enable),
      .btn_level(lvl_h), .btn_pulse(pls_h), .multi_press(mp_h));

   btn_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) u_dut_l (
      .clock(clock), .reset(reset), .btn_raw(~btn_raw), .enable(enable),
      .btn_level(lvl_l), .btn_pulse(pls_l), .multi_press(mp_l));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pressed-level history plus an "all released since last press" flag.
   logic [2:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvld = '0, m_pulse = '0;
   logic       m_multi = 1'b0, m_armed = 1'b1;
   logic [2:0] m_hist[$];

   task automatic model_step(input logic [2:0] raw, input logic en, input logic rst);
      logic [2:0] nlvl, rise, dummy;
      bit all_diff;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvld = '0; m_pulse = '0;
         m_multi = 1'b0; m_armed = 1'b1;
         m_hist.delete();
         return;
      end
      m_hist.push_back(m_s2);
      if (m_hist.size() > D) dummy = m_hist.pop_front();
      nlvl = m_lvl;
      // A level flips once the last D synchronised samples all disagree with it.
      if (m_hist.size() == D) begin
         for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i][b] == m_lvl[b]) all_diff = 1'b0;
            if (all_diff) nlvl[b] = ~m_lvl[b];
         end
      end
      rise = m_lvl & ~m_lvld;
      m_pulse = '0;
      m_multi = 1'b0;
      if (m_armed && rise != 0) begin
         m_armed = 1'b0;
         if ($countones(rise) == 1) m_pulse = en ? rise : 3'b000;
         else                       m_multi = en;
      end else if (!m_armed && m_lvl == 0) begin
         m_armed = 1'b1;
      end
      m_s2 = m_s1; m_s1 = raw; m_lvld = m_lvl; m_lvl = nlvl;
   endtask

   // Pulse monitor for the directed scenarios (cycle index is 1-based from clr_mon).
   int cyc_no, p_cnt, p_first, mp_cnt;
   logic [2:0] p_val;

   task automatic clr_mon();
      cyc_no = 0; p_cnt = 0; p_first = 0; mp_cnt = 0; p_val = '0;
   endtask

   task automatic cyc(input logic [2:0] raw, input logic en, input logic rst);
      btn_raw = raw; enable = en; reset = rst;
      @(posedge clock);
      #1;
      model_step(raw, en, rst);
      chk("level_h", 32'(lvl_h), 32'(m_lvl));
      chk("pulse_h", 32'(pls_h), 32'(m_pulse));
      chk("multi_h", 32'(mp_h),  32'(m_multi));
      chk("level_l", 32'(lvl_l), 32'(m_lvl));
      chk("pulse_l", 32'(pls_l), 32'(m_pulse));
      chk("multi_l", 32'(mp_l),  32'(m_multi));
      cyc_no++;
      if (mp_h) mp_cnt++;
      if (pls_h != 0) begin
         p_cnt++;
         if (p_first == 0) begin p_first = cyc_no; p_val = pls_h; end
      end
   endtask

   task automatic hold(input logic [2:0] raw, input logic en, input int n);
      for (int i = 0; i < n; i++) cyc(raw, en, 1'b0);
   endtask

   initial begin
      clr_mon();
      // Reset state
      cyc(3'b000, 1'b1, 1'b1);
      chk("rst_out", 32'({lvl_h, pls_h, mp_h}), 32'h0);

      // Clean press: capture at cycle 1, pulse visible after edge 1+D+2
      clr_mon();
      hold(3'b010, 1'b1, 20);
      chk("clean_lat", 32'(p_first), 32'(D + 3));
      chk("clean_cnt", 32'(p_cnt), 32'd1);
      chk("clean_val", 32'(p_val), 32'h2);

      // Bounce: final stable 1 captured at cycle 5
      cyc(3'b000, 1'b1, 1'b1);
      clr_mon();
      cyc(3'b001, 1'b1, 1'b0); cyc(3'b000, 1'b1, 1'b0);
      cyc(3'b001, 1'b1, 1'b0); cyc(3'b000, 1'b1, 1'b0);
      hold(3'b001, 1'b1, 12);
      chk("bounce_lat", 32'(p_first), 32'(5 + D + 2));
      chk("bounce_cnt", 32'(p_cnt), 32'd1);
      chk("bounce_val", 32'(p_val), 32'h1);

      // Overlap: second button while first held gives nothing
      cyc(3'b000, 1'b1, 1'b1);
      clr_mon();
      hold(3'b100, 1'b1, 10);
      hold(3'b101, 1'b1, 10);
      chk("ovl_first", 32'(p_val), 32'h4);
      chk("ovl_cnt1", 32'(p_cnt), 32'd1);
      hold(3'b000, 1'b1, 10);
      hold(3'b001, 1'b1, 10);
      chk("ovl_cnt2", 32'(p_cnt), 32'd2);

      // Chord
      hold(3'b000, 1'b1, 10);
      clr_mon();
      hold(3'b011, 1'b1, 10);
      chk("chord_mp", 32'(mp_cnt), 32'd1);
      chk("chord_pls", 32'(p_cnt), 32'd0);
      hold(3'b000, 1'b1, 10);
      clr_mon();
      hold(3'b010, 1'b1, 10);
      chk("chord_next", 32'(p_val), 32'h2);

      // Enable low consumes the press
      hold(3'b000, 1'b1, 10);
      clr_mon();
      hold(3'b001, 1'b0, 10);
      hold(3'b001, 1'b1, 5);
      chk("en_off", 32'(p_cnt), 32'd0);
      hold(3'b000, 1'b1, 10);
      clr_mon();
      hold(3'b001, 1'b1, 10);
      chk("en_on", 32'(p_cnt), 32'd1);

      // Reset mid-debounce (cnt reaches 2 after the 4th edge)
      hold(3'b000, 1'b1, 10);
      hold(3'b010, 1'b1, 4);
      cyc(3'b010, 1'b1, 1'b1);
      chk("rstmid_out", 32'({lvl_h, pls_h, mp_h, lvl_l, pls_l, mp_l}), 32'h0);
      clr_mon();
      hold(3'b010, 1'b1, 12);
      chk("rstmid_lat", 32'(p_first), 32'(D + 3));
      chk("rstmid_val", 32'(p_val), 32'h2);

      // Randomised segments with bounces, chords, enable gaps and resets
      for (int s = 0; s < 400; s++) begin
         logic [2:0] r;
         logic       e;
         int         n;
         r = 3'($urandom_range(0, 7));
         e = ($urandom_range(0, 3) != 0);
         n = $urandom_range(1, 9);
         if ($urandom_range(0, 39) == 0) cyc(r, e, 1'b1);
         else                            hold(r, e, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
